// File: rtl/vga_pixel_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_feeder_if
//  Description : Bundle of the frame-buffer write stream, the VGA controller
//                pixel request/response and the feeder status outputs.
//                master : upstream writer + VGA controller side
//                slave  : the pixel feeder itself
//  Ports       : iWR_DATA/iWR_VALID/oWR_READY  - RGB565 write handshake
//                iFRAME_START                  - frame flush pulse
//                iRequest                      - pixel pop request
//                oRed/oGreen/oBlue             - 10-bit expanded colour
//                oPix_X/oPix_Y                 - position of next pixel
//                oFill/oUnderflow/oUflow_Cnt   - FIFO status
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_feeder_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int c_FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]         iWR_DATA;
    logic                iWR_VALID;
    logic                oWR_READY;
    logic                iFRAME_START;
    logic                iRequest;
    logic [9:0]          oRed;
    logic [9:0]          oGreen;
    logic [9:0]          oBlue;
    logic [9:0]          oPix_X;
    logic [8:0]          oPix_Y;
    logic [c_FILL_W-1:0] oFill;
    logic                oUnderflow;
    logic [15:0]         oUflow_Cnt;

    modport master (
        output iWR_DATA, iWR_VALID, iFRAME_START, iRequest,
        input  oWR_READY, oRed, oGreen, oBlue, oPix_X, oPix_Y,
               oFill, oUnderflow, oUflow_Cnt
    );

    modport slave (
        input  iWR_DATA, iWR_VALID, iFRAME_START, iRequest,
        output oWR_READY, oRed, oGreen, oBlue, oPix_X, oPix_Y,
               oFill, oUnderflow, oUflow_Cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_feeder
//  Description : Small synchronous FIFO between the frame-buffer reader and
//                the VGA controller. Pops one RGB565 word per pixel request,
//                presents it as 10-bit R/G/B one cycle later, tracks the
//                active-area position and reports underflow.
//  Ports       : iCLK  - pixel clock
//                iRST  - synchronous active-high reset
//                bus   - vga_pixel_feeder_if.slave (stream, request, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACT      = 800,
    parameter int V_ACT      = 480
) (
    input  logic                iCLK,
    input  logic                iRST,
    vga_pixel_feeder_if.slave   bus
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_FW = c_AW + 1;

    localparam logic [c_FW-1:0] c_FULL_LVL = c_FW'(FIFO_DEPTH);
    localparam logic [9:0]      c_X_LAST   = 10'(H_ACT - 1);
    localparam logic [8:0]      c_Y_LAST   = 9'(V_ACT - 1);

    // Storage (no reset needed: contents are only read when fill says valid)
    logic [15:0] r_mem_q [FIFO_DEPTH];

    logic [c_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_FW-1:0] r_fill_q,   w_fill_d;
    logic [9:0]      r_red_q,    w_red_d;
    logic [9:0]      r_green_q,  w_green_d;
    logic [9:0]      r_blue_q,   w_blue_d;
    logic [9:0]      r_pix_x_q,  w_pix_x_d;
    logic [8:0]      r_pix_y_q,  w_pix_y_d;
    logic            r_uflow_q,  w_uflow_d;
    logic [15:0]     r_ucnt_q,   w_ucnt_d;

    logic        w_empty;
    logic        w_full;
    logic        w_ready;
    logic        w_push;
    logic        w_req;
    logic        w_pop;
    logic        w_uflow_ev;
    logic [15:0] w_rd_word;

    // Ready depends only on registered fill and the flush/reset inputs,
    // never on iRequest, so a pop cannot open a same-cycle write slot.
    assign w_empty    = (r_fill_q == '0);
    assign w_full     = (r_fill_q == c_FULL_LVL);
    assign w_ready    = !w_full && !bus.iFRAME_START && !iRST;
    assign w_push     = bus.iWR_VALID && w_ready;
    // A frame start swallows any coincident request entirely.
    assign w_req      = bus.iRequest && !bus.iFRAME_START;
    // Empty is judged on the pre-write state: no write-to-read bypass.
    assign w_pop      = w_req && !w_empty;
    assign w_uflow_ev = w_req && w_empty;
    assign w_rd_word  = r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_fill_d   = r_fill_q;
        w_red_d    = r_red_q;
        w_green_d  = r_green_q;
        w_blue_d   = r_blue_q;
        w_pix_x_d  = r_pix_x_q;
        w_pix_y_d  = r_pix_y_q;
        w_uflow_d  = r_uflow_q;
        w_ucnt_d   = r_ucnt_q;

        if (bus.iFRAME_START) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_fill_d   = '0;
            w_red_d    = '0;
            w_green_d  = '0;
            w_blue_d   = '0;
            w_pix_x_d  = '0;
            w_pix_y_d  = '0;
            w_ucnt_d   = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                w_fill_d = r_fill_q + c_FW'(1);
            end else if (w_pop && !w_push) begin
                w_fill_d = r_fill_q - c_FW'(1);
            end

            // Bit replication fills the low bits so full scale maps to 0x3FF.
            if (w_pop) begin
                w_red_d   = {w_rd_word[15:11], w_rd_word[15:11]};
                w_green_d = {w_rd_word[10:5],  w_rd_word[10:7]};
                w_blue_d  = {w_rd_word[4:0],   w_rd_word[4:0]};
            end else if (w_uflow_ev) begin
                w_red_d   = '0;
                w_green_d = '0;
                w_blue_d  = '0;
            end

            if (w_uflow_ev) begin
                w_uflow_d = 1'b1;
                if (r_ucnt_q != 16'hFFFF) begin
                    w_ucnt_d = r_ucnt_q + 16'd1;
                end
            end

            // Every accepted request consumes a pixel slot, even if starved.
            if (w_req) begin
                if (r_pix_x_q == c_X_LAST) begin
                    w_pix_x_d = '0;
                    w_pix_y_d = (r_pix_y_q == c_Y_LAST) ? 9'd0 : r_pix_y_q + 9'd1;
                end else begin
                    w_pix_x_d = r_pix_x_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_fill_q   <= '0;
            r_red_q    <= '0;
            r_green_q  <= '0;
            r_blue_q   <= '0;
            r_pix_x_q  <= '0;
            r_pix_y_q  <= '0;
            r_uflow_q  <= 1'b0;
            r_ucnt_q   <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_fill_q   <= w_fill_d;
            r_red_q    <= w_red_d;
            r_green_q  <= w_green_d;
            r_blue_q   <= w_blue_d;
            r_pix_x_q  <= w_pix_x_d;
            r_pix_y_q  <= w_pix_y_d;
            r_uflow_q  <= w_uflow_d;
            r_ucnt_q   <= w_ucnt_d;
        end
    end

    // w_push is already gated by reset through w_ready.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= bus.iWR_DATA;
        end
    end

    assign bus.oWR_READY  = w_ready;
    assign bus.oRed       = r_red_q;
    assign bus.oGreen     = r_green_q;
    assign bus.oBlue      = r_blue_q;
    assign bus.oPix_X     = r_pix_x_q;
    assign bus.oPix_Y     = r_pix_y_q;
    assign bus.oFill      = r_fill_q;
    assign bus.oUnderflow = r_uflow_q;
    assign bus.oUflow_Cnt = r_ucnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_feeder
//  Description : Scoreboard bench for vga_pixel_feeder. A queue-based model
//                predicts FIFO contents, position, underflow state and the
//                colour seen one cycle after each request/flush/reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_feeder;
    localparam int DEPTH = 16;
    localparam int HA    = 800;
    localparam int VA    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_pixel_feeder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    vga_pixel_feeder #(
        .FIFO_DEPTH (DEPTH),
        .H_ACT      (HA),
        .V_ACT      (VA)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] mq[$];
    int          pidx   = 0;
    bit          m_uflow = 1'b0;
    int          m_ucnt = 0;
    logic [29:0] expq[$];

    function automatic logic [29:0] expand(input logic [15:0] w);
        int r, g, b;
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        return {10'(r * 33), 10'(g * 16 + g / 4), 10'(b * 33)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus model update and state checks.
    task automatic cyc(input bit r, input bit v, input logic [15:0] d,
                       input bit fs, input bit q, output bit accepted);
        bit          rdy;
        logic [29:0] e;
        rst              = r;
        bus.iWR_VALID    = v;
        bus.iWR_DATA     = d;
        bus.iFRAME_START = fs;
        bus.iRequest     = q;
        #1;
        rdy = !r && !fs && (mq.size() < DEPTH);
        chk("ready", 32'(bus.oWR_READY), 32'(rdy));
        accepted = v && rdy;
        if (r) begin
            mq.delete(); pidx = 0; m_uflow = 1'b0; m_ucnt = 0;
            expq.push_back('0);
        end else if (fs) begin
            mq.delete(); pidx = 0; m_ucnt = 0;
            expq.push_back('0);
        end else begin
            if (q) begin
                if (mq.size() > 0) begin
                    e = expand(mq.pop_front());
                end else begin
                    e = '0;
                    m_uflow = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
                pidx = (pidx + 1) % (HA * VA);
                expq.push_back(e);
            end
            if (accepted) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("fill",   32'(bus.oFill),      32'(mq.size()));
        chk("pix_x",  32'(bus.oPix_X),     32'(pidx % HA));
        chk("pix_y",  32'(bus.oPix_Y),     32'(pidx / HA));
        chk("uflow",  32'(bus.oUnderflow), 32'(m_uflow));
        chk("ucnt",   32'(bus.oUflow_Cnt), 32'(m_ucnt));
    endtask

    // Monitor: one colour result is due after every reset/flush/request edge.
    initial begin
        logic [29:0] e;
        bit          ev;
        forever begin
            @(posedge clk);
            ev = rst || bus.iFRAME_START || bus.iRequest;
            if (ev) begin
                #2;
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard: output with no expectation at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    chk("rgb", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          a;
        int          acc;
        logic [15:0] src;
        logic [15:0] t1 [4];
        bit          r, fs, v, q;

        bus.iWR_DATA = '0; bus.iWR_VALID = 1'b0;
        bus.iFRAME_START = 1'b0; bus.iRequest = 1'b0;
        t1[0] = 16'hF800; t1[1] = 16'h07E0; t1[2] = 16'h001F; t1[3] = 16'hFFFF;

        // 1: reset, write four primaries, pop them
        cyc(1, 0, '0, 0, 0, a);
        cyc(1, 1, 16'h1234, 0, 1, a);
        for (int i = 0; i < 4; i++) cyc(0, 1, t1[i], 0, 0, a);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 1, a);
        cyc(0, 0, '0, 0, 0, a);
        chk("t1_white", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'({10'h3FF, 10'h3FF, 10'h3FF}));

        // 2: fill to full, one pop, exactly one more accept
        acc = 0;
        src = 16'($urandom);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, src, 0, 0, a);
            if (a) begin acc++; src = 16'($urandom); end
        end
        chk("t2_acc16", 32'(acc), 32'd16);
        chk("t2_full", 32'(bus.oFill), 32'd16);
        cyc(0, 1, src, 0, 1, a);
        if (a) begin acc++; src = 16'($urandom); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, src, 0, 0, a);
            if (a) begin acc++; src = 16'($urandom); end
        end
        chk("t2_acc17", 32'(acc), 32'd17);

        // 3: drain, then underflow three times, then flush
        for (int i = 0; i < 16; i++) cyc(0, 0, '0, 0, 1, a);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1, a);
        chk("t3_ucnt", 32'(bus.oUflow_Cnt), 32'd3);
        cyc(0, 0, '0, 1, 0, a);
        chk("t3_uflow_kept", 32'(bus.oUnderflow), 32'd1);

        // 4: ten words, three pops, then flush with write+request
        for (int i = 0; i < 10; i++) cyc(0, 1, 16'($urandom), 0, 0, a);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1, a);
        cyc(0, 1, 16'hABCD, 1, 1, a);
        chk("t4_fill", 32'(bus.oFill), 32'd0);

        // 5: full-frame position walk with the FIFO kept non-empty
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'($urandom), 0, 0, a);
        for (int i = 0; i < HA * VA + 5; i++) cyc(0, 1, 16'($urandom), 0, 1, a);
        chk("t5_x", 32'(bus.oPix_X), 32'd5);
        chk("t5_y", 32'(bus.oPix_Y), 32'd0);

        // 6: reset mid-stream with fill 7 and x 123
        cyc(0, 0, '0, 1, 0, a);
        for (int i = 0; i < 7; i++) cyc(0, 1, 16'($urandom), 0, 0, a);
        for (int i = 0; i < 123; i++) cyc(0, 1, 16'($urandom), 0, 1, a);
        chk("t6_pre_x", 32'(bus.oPix_X), 32'd123);
        cyc(1, 1, 16'($urandom), 0, 1, a);
        cyc(0, 0, '0, 0, 1, a);
        chk("t6_uflow", 32'(bus.oUnderflow), 32'd1);

        // Random traffic; the source holds a word until it is accepted
        src = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            fs = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 2) != 0);
            q  = ($urandom_range(0, 2) != 0);
            cyc(r, v, src, fs, q, a);
            if (a) src = 16'($urandom);
        end

        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, a);
        chk("sb_drain", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
